// File: rtl/countdown_with_subtractor.sv
// countdown_with_subtractor: loadable 32-bit countdown stepping by a 4-bit amount, saturating at zero with a sticky underflow flag.
module countdown_with_subtractor (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        enable,
  input  logic [3:0]  sub_value,
  output logic [31:0] count,
  output logic        busy,
  output logic        done,
  output logic        underflow
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic        uf_q, uf_d;
  logic [31:0] step;
  logic        above;
  assign step  = {28'd0, sub_value};
  assign above = count_q > step;
  // a zero step never advances, so it cannot finish or underflow the countdown
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    uf_d    = uf_q;
    if (load) begin
      count_d = load_value;
      uf_d    = 1'b0;
      state_d = (load_value == 32'd0) ? DONE : RUN;
    end else if (state_q == RUN && enable && sub_value != 4'd0) begin
      count_d = above ? count_q - step : 32'd0;
      uf_d    = uf_q | (count_q < step);
      state_d = above ? RUN : DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 32'd0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      uf_q    <= uf_d;
    end
  end
  assign count     = count_q;
  assign busy      = state_q == RUN;
  assign done      = state_q == DONE;
  assign underflow = uf_q;
endmodule

// File: tb/tb_countdown_with_subtractor.sv
// tb_countdown_with_subtractor: directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_countdown_with_subtractor;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [31:0] load_value = '0;
  logic        enable = 1'b0;
  logic [3:0]  sub_value = '0;
  logic [31:0] count;
  logic        busy, done, underflow;
  logic [34:0] obs;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_cnt = '0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_uf = 1'b0;

  countdown_with_subtractor dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .sub_value(sub_value), .count(count), .busy(busy),
    .done(done), .underflow(underflow)
  );

  always #5 clk = ~clk;
  assign obs = {count, busy, done, underflow};

  function automatic void model(input logic ld, input logic [31:0] lv, input logic en, input logic [3:0] sv);
    longint r;
    if (ld) begin
      m_cnt = lv; m_uf = 1'b0; m_done = (lv == 0); m_busy = (lv != 0);
    end else if (m_busy && en && sv != 0) begin
      r = longint'(m_cnt) - longint'(sv);
      if (r <= 0) begin
        m_uf = m_uf | (r < 0); m_cnt = 0; m_busy = 1'b0; m_done = 1'b1;
      end else m_cnt = 32'(r);
    end else m_done = 1'b0;
  endfunction

  task automatic step(input logic ld, input logic [31:0] lv, input logic en, input logic [3:0] sv);
    @(negedge clk);
    load = ld; load_value = lv; enable = en; sub_value = sv;
    @(posedge clk);
    model(ld, lv, en, sv);
    #1;
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if (obs !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_async: got %h want %h", obs, 35'd0);
    end
    load = 1'b1; load_value = 32'd9; enable = 1'b1; sub_value = 4'd1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_held: got %h want %h", obs, 35'd0);
    end
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
  endtask

  task automatic test_underflow;
    logic [34:0] e [6] = '{{32'd10,3'b100}, {32'd7,3'b100}, {32'd4,3'b100},
                           {32'd1,3'b100}, {32'd0,3'b011}, {32'd0,3'b001}};
    for (int i = 0; i < 6; i++) begin
      step(i == 0, 32'd10, 1'b1, 4'd3);
      vectors++;
      if (obs !== e[i]) begin
        miscompares++;
        $display("FAIL underflow_seq[%0d]: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_exact;
    logic [34:0] e [5] = '{{32'd12,3'b100}, {32'd8,3'b100}, {32'd4,3'b100},
                           {32'd0,3'b010}, {32'd0,3'b000}};
    for (int i = 0; i < 5; i++) begin
      step(i == 0, 32'd12, 1'b1, 4'd4);
      vectors++;
      if (obs !== e[i]) begin
        miscompares++;
        $display("FAIL exact_seq[%0d]: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_zero_load;
    logic [34:0] e [3] = '{{32'd0,3'b010}, {32'd0,3'b000}, {32'd0,3'b000}};
    for (int i = 0; i < 3; i++) begin
      step(i == 0, 32'd0, 1'b1, 4'd3);
      vectors++;
      if (obs !== e[i]) begin
        miscompares++;
        $display("FAIL zero_load[%0d]: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_max;
    logic [34:0] e [4] = '{{32'hFFFFFFF0,3'b100}, {32'hFFFFFFF0,3'b100},
                           {32'hFFFFFFF0,3'b100}, {32'hFFFFFFE1,3'b100}};
    logic        en [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    step(1'b1, 32'hFFFFFFFF, 1'b0, 4'd15);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'd0, en[i], 4'd15);
      vectors++;
      if (obs !== e[i]) begin
        miscompares++;
        $display("FAIL max_seq[%0d]: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_reload;
    logic [34:0] want;
    step(1'b1, 32'd100, 1'b1, 4'd5);
    for (int i = 1; i <= 10; i++) step(1'b0, 32'd0, 1'b1, 4'd5);
    vectors++;
    if (count !== 32'd50) begin
      miscompares++;
      $display("FAIL reload_mid: got %0d want 50", count);
    end
    want = {32'd7, 3'b100};
    step(1'b1, 32'd7, 1'b1, 4'd5);
    vectors++;
    if (obs !== want) begin
      miscompares++;
      $display("FAIL reload_wins: got %h want %h", obs, want);
    end
    step(1'b0, 32'd0, 1'b0, 4'd5);
    vectors++;
    if (obs !== want) begin
      miscompares++;
      $display("FAIL reload_hold: got %h want %h", obs, want);
    end
  endtask

  task automatic test_async_reset;
    step(1'b1, 32'd100, 1'b1, 4'd5);
    for (int i = 1; i <= 12; i++) step(1'b0, 32'd0, 1'b1, 4'd5);
    vectors++;
    if (obs !== {32'd40, 3'b100}) begin
      miscompares++;
      $display("FAIL areset_pre: got %h want %h", obs, {32'd40, 3'b100});
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (obs !== 35'd0) begin
      miscompares++;
      $display("FAIL areset_immediate: got %h want %h", obs, 35'd0);
    end
    load = 1'b1; load_value = 32'd5;
    @(posedge clk);
    #1;
    vectors++;
    if (obs !== 35'd0) begin
      miscompares++;
      $display("FAIL areset_ignore_load: got %h want %h", obs, 35'd0);
    end
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    m_cnt = '0; m_busy = 1'b0; m_done = 1'b0; m_uf = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 32'd0, 1'b1, 4'd5);
      vectors++;
      if (obs !== 35'd0) begin
        miscompares++;
        $display("FAIL areset_after[%0d]: got %h want %h", i, obs, 35'd0);
      end
    end
  endtask

  task automatic test_random;
    logic        ld, en;
    logic [31:0] lv;
    logic [3:0]  sv;
    for (int i = 0; i < 600; i++) begin
      ld = ($urandom_range(0, 9) == 0);
      lv = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 80));
      en = ($urandom_range(0, 3) != 0);
      sv = 4'($urandom_range(0, 15));
      step(ld, lv, en, sv);
      vectors++;
      if (obs !== {m_cnt, m_busy, m_done, m_uf}) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, {m_cnt, m_busy, m_done, m_uf});
      end
    end
  endtask

  initial begin
    test_reset;
    test_underflow;
    test_exact;
    test_zero_load;
    test_max;
    test_reload;
    test_async_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
